// File: rtl/sc_core_oz_pkg.sv
// Shared types for the oz core load/store unit: FSM states, RV32I access sizes
// and the misalignment rule used when an instruction is accepted.
package sc_core_oz_pkg;

    localparam int MEM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_size_e;

    // Reserved encodings (including unsigned stores) are reported as misaligned.
    function automatic logic lsu_misaligned(input logic we, input logic [2:0] f3,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (f3)
            F3_B:    mis = 1'b0;
            F3_H:    mis = addr_lo[0];
            F3_W:    mis = (addr_lo != 2'b00);
            F3_BU:   mis = we;
            F3_HU:   mis = we | addr_lo[0];
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/sc_core_oz_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication,
// load lane extraction with sign or zero extension.
module sc_core_oz_lsu_align
    import sc_core_oz_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_shift;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign rdata_shift = rdata >> {addr_lo, 3'b000};

    always_comb begin
        rdata_ext = rdata_shift;
        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            F3_H:    rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            F3_BU:   rdata_ext = {24'h000000, rdata_shift[7:0]};
            F3_HU:   rdata_ext = {16'h0000, rdata_shift[15:0]};
            default: rdata_ext = rdata_shift;
        endcase
    end

endmodule

// File: rtl/sc_core_oz_lsu.sv
// Load/store unit for the oz core: one outstanding access on a req/gnt/rvalid
// memory port, with misalignment detection and a response timeout.
//
// state   | meaning
// IDLE    | waiting for lsu_valid; captures the instruction
// REQ     | mem_req held until mem_gnt
// WAIT    | load granted, waiting for mem_rvalid
// DONE    | one-cycle lsu_done pulse, no new instruction accepted
module sc_core_oz_lsu
    import sc_core_oz_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_stall,
    output logic        lsu_misalign,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(MEM_TIMEOUT - 1);

    lsu_state_e  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic        misalign_q;
    logic        err_q;
    logic [CW-1:0] cnt;
    logic        timeout;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;

    sc_core_oz_lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (be_lane),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // Counter runs from REQ entry, so the budget covers grant plus response.
    assign timeout = (cnt >= CNT_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    misalign_q <= 1'b0;
                    err_q      <= 1'b0;
                    if (lsu_valid) begin
                        addr_q   <= lsu_addr;
                        wdata_q  <= lsu_wdata;
                        funct3_q <= lsu_funct3;
                        we_q     <= lsu_we;
                        cnt      <= '0;
                        if (lsu_misaligned(lsu_we, lsu_funct3, lsu_addr[1:0])) begin
                            misalign_q <= 1'b1;
                            rdata_q    <= '0;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        if (we_q) begin
                            rdata_q <= '0;
                            state   <= ST_DONE;
                        end else if (mem_rvalid) begin
                            rdata_q <= rdata_ext;
                            state   <= ST_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ST_WAIT;
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= rdata_ext;
                        state   <= ST_DONE;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lsu_done     = (state == ST_DONE);
    assign lsu_rdata    = rdata_q;
    assign lsu_misalign = lsu_done & misalign_q;
    assign lsu_err      = lsu_done & err_q;
    assign lsu_stall    = lsu_valid & ~lsu_done;

    // Reset gating keeps the memory port quiet combinationally while rst is high.
    assign mem_req   = (state == ST_REQ) & ~rst;
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be_lane : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_lane;

endmodule

// File: tb/tb_sc_core_oz_lsu.sv
// Directed bench for sc_core_oz_lsu: stimulus pushes expected memory requests
// and completions into queues; a negedge monitor pops and compares them.
module tb_sc_core_oz_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_stall;
    logic        lsu_misalign;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    sc_core_oz_lsu #(.MEM_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid    (lsu_valid),
        .lsu_we       (lsu_we),
        .lsu_funct3   (lsu_funct3),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_rdata    (lsu_rdata),
        .lsu_done     (lsu_done),
        .lsu_stall    (lsu_stall),
        .lsu_misalign (lsu_misalign),
        .lsu_err      (lsu_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rd;
        logic        mis;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } mreq_t;

    resp_t exp_resp[$];
    mreq_t exp_mem[$];
    resp_t r;
    mreq_t m;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_v = 1'b0;
    logic no_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (lsu_valid && !prev_v) start_cyc = cyc;
            prev_v = lsu_valid;
            if (lsu_valid) chk("stall", {31'b0, lsu_stall}, {31'b0, ~lsu_done});
            if (no_req) chk("no_mem_req", {31'b0, mem_req}, 32'd0);
            if (mem_req && mem_gnt) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_req_unexpected", {31'b0, mem_req}, 32'd0);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_be", {28'b0, mem_be}, {28'b0, m.be});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (lsu_done) begin
                if (exp_resp.size() == 0) begin
                    chk("done_unexpected", {31'b0, lsu_done}, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    if (r.chk_rd) chk("lsu_rdata", lsu_rdata, r.rdata);
                    chk("lsu_misalign", {31'b0, lsu_misalign}, {31'b0, r.mis});
                    chk("lsu_err", {31'b0, lsu_err}, {31'b0, r.err});
                    chk("latency", 32'(cyc - start_cyc), 32'(r.lat));
                end
            end
        end
    end

    // gnt_dly < 0: never grant; rv_dly < 0: never return data.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_mis, input logic exp_err, input int exp_lat);
        int n;
        resp_t er;
        mreq_t em;
        er.rdata  = exp_rd;
        er.chk_rd = !we || exp_mis || exp_err;
        er.mis    = exp_mis;
        er.err    = exp_err;
        er.lat    = exp_lat;
        exp_resp.push_back(er);
        if (gnt_dly >= 0) begin
            em.addr  = {addr[31:2], 2'b00};
            em.be    = exp_be;
            em.wdata = exp_wd;
            em.we    = we;
            exp_mem.push_back(em);
        end
        tick();
        no_req     = exp_mis;
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        if (gnt_dly >= 0) begin
            n = 0;
            while (!mem_req && n < 20) begin
                tick();
                n++;
            end
            repeat (gnt_dly) tick();
            mem_gnt = 1'b1;
            if (!we && rv_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!we && rv_dly > 0) begin
                repeat (rv_dly - 1) tick();
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                tick();
                mem_rvalid = 1'b0;
            end
        end
        n = 0;
        while (!lsu_done && n < 400) begin
            tick();
            n++;
        end
        if (!lsu_done) chk("done_wait", {31'b0, lsu_done}, 32'd1);
        tick();
        lsu_valid = 1'b0;
        no_req    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        lsu_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) tick();
        chk("rst_done", {31'b0, lsu_done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_err", {30'b0, lsu_err, lsu_misalign}, 32'd0);
        rst = 1'b0;
        tick();

        //     we    f3      addr          wdata         gnt rv  rdata         be      exp_wd        exp_rd        mis   err   lat
        access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 2);
        access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 2);
        access(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 2, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0, 4);
        access(1'b0, 3'b001, 32'h0000_0102, 32'h0,         0, 3, 32'h8001_5555, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 5);
        access(1'b0, 3'b101, 32'h0000_0102, 32'h0,         0, 3, 32'h8001_5555, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 1'b0, 5);
        access(1'b0, 3'b010, 32'h0000_0104, 32'h0,         0, 0, 32'h1234_5678, 4'b1111, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 2);
        access(1'b0, 3'b000, 32'h0000_0101, 32'h0,         1, 1, 32'h1122_8033, 4'b0010, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 4);
        access(1'b0, 3'b100, 32'h0000_0103, 32'h0,         0, 0, 32'hF000_0000, 4'b1000, 32'h0,        32'h0000_00F0, 1'b0, 1'b0, 2);
        access(1'b0, 3'b010, 32'h0000_0101, 32'h0,        -1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1);
        access(1'b1, 3'b001, 32'h0000_0101, 32'h5555_AAAA,-1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1);
        access(1'b0, 3'b011, 32'h0000_0000, 32'h0,        -1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1);
        access(1'b0, 3'b010, 32'h0000_0200, 32'h0,        -1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 9);
        access(1'b0, 3'b010, 32'h0000_0300, 32'h0,         0,-1, 32'h0,        4'b1111, 32'h0,        32'h0,        1'b0, 1'b1, 9);

        // Stray responses while idle must not complete anything.
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        chk("idle_rsp_no_done", {31'b0, lsu_done}, 32'd0);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        repeat (3) tick();
        chk("idle_rsp_no_done_later", {31'b0, lsu_done}, 32'd0);

        // Reset while mem_req is high.
        lsu_valid  = 1'b1;
        lsu_we     = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h0000_0400;
        lsu_wdata  = 32'h1111_2222;
        tick();
        chk("abort_req_active", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_req_low", {31'b0, mem_req}, 32'd0);
        chk("abort_we_low", {31'b0, mem_we}, 32'd0);
        chk("abort_be_low", {28'b0, mem_be}, 32'd0);
        lsu_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset while waiting for load data, then a late rvalid.
        m.addr = 32'h0000_0500; m.be = 4'b1111; m.wdata = 32'h0; m.we = 1'b0;
        exp_mem.push_back(m);
        lsu_valid  = 1'b1;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h0000_0500;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("wait_abort_req_low", {31'b0, mem_req}, 32'd0);
        chk("wait_abort_no_done", {31'b0, lsu_done}, 32'd0);
        lsu_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_no_done", {31'b0, lsu_done}, 32'd0);
        repeat (4) tick();
        chk("late_rvalid_idle_req", {31'b0, mem_req}, 32'd0);
        chk("late_rvalid_rdata", lsu_rdata, 32'd0);

        access(1'b1, 3'b010, 32'h0000_0104, 32'h0BAD_F00D, 0, 0, 32'h0, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 2);

        repeat (5) tick();
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
